// File: rtl/slug_runctl.sv
// Run-control and program-load sequencer for the slug 4-bit core.
// Owns the core clock enable/reset and handles RUN/HALT/STEP/LOAD commands plus a fetch breakpoint.
module slug_runctl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_waddr,
  output logic [DATA_W-1:0] prog_wdata,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] core_prog_addr,
  output logic              core_ce,
  output logic              core_rst,
  output logic              halted,
  output logic              bp_hit,
  output logic              step_done
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    OP_RUN  = 2'b00,
    OP_HALT = 2'b01,
    OP_STEP = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_HALT,
    S_RUN,
    S_STEP,
    S_LOAD
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       flush_q, flush_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic                bp_hit_q, bp_hit_d;
  logic                skip_q, skip_d;
  op_e                 op;
  logic                bp_match;

  assign op       = op_e'(cmd_op);
  assign bp_match = bp_en && (core_prog_addr == bp_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FLUSH;
      flush_q  <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      bp_hit_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      bp_hit_q <= bp_hit_d;
      skip_q   <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    bp_hit_d  = bp_hit_q;
    skip_d    = 1'b0;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    prog_we   = 1'b0;
    core_ce   = 1'b0;
    core_rst  = 1'b1;
    step_done = 1'b0;

    case (state_q)
      S_FLUSH: begin
        core_rst = 1'b0;
        core_ce  = 1'b1;
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          state_d = S_HALT;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end

      S_HALT: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          bp_hit_d = 1'b0;
          case (op)
            OP_RUN: begin
              state_d = S_RUN;
              skip_d  = 1'b1;
            end
            OP_STEP: state_d = S_STEP;
            OP_LOAD: begin
              addr_d  = cmd_addr;
              rem_d   = cmd_len;
              state_d = (cmd_len == '0) ? S_FLUSH : S_LOAD;
            end
            default: state_d = S_HALT;
          endcase
        end
      end

      S_RUN: begin
        cmd_ready = (op == OP_HALT);
        // A breakpoint hit wins over a HALT accepted in the same cycle so the stop is reported.
        if (bp_match && !skip_q) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else begin
          core_ce = 1'b1;
          if (cmd_valid && cmd_ready) begin
            bp_hit_d = 1'b0;
            state_d  = S_HALT;
          end
        end
      end

      S_STEP: begin
        core_ce   = 1'b1;
        step_done = 1'b1;
        state_d   = S_HALT;
      end

      S_LOAD: begin
        core_rst = 1'b0;
        ld_ready = 1'b1;
        if (ld_valid) begin
          prog_we = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = S_FLUSH;
        end
      end

      default: state_d = S_FLUSH;
    endcase
  end

  assign prog_waddr = addr_q;
  assign prog_wdata = ld_data;
  assign halted     = (state_q == S_HALT);
  assign bp_hit     = bp_hit_q;

endmodule
